// File: rtl/pwm_regs_multi.sv
// pwm_regs_multi: register bank for a shared-counter, NCH-channel PWM block.
// Holds shadow/active period and compare registers (the active copy loads from
// the shadow copy at counter overflow or on a forced load), sticky status flags
// with a registered interrupt, and immediate-effect counter/channel controls.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   read, write, addr, data_write   decoder access (write has priority)
//   data_read                       registered read data, 0 when no read
//   counter_val, counter_ovf        live counter value and wrap pulse
//   period, compare1, compare2      active copies of the shadowed registers
//   en, count_reset, upnotdown,
//   prescale                        counter control
//   pwm_en, functions               per-channel enable and function byte
//   irq                             registered interrupt
module pwm_regs_multi #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [5:0]        addr,
    input  logic [7:0]        data_write,
    output logic [7:0]        data_read,
    input  logic [CW-1:0]     counter_val,
    input  logic              counter_ovf,
    output logic [CW-1:0]     period,
    output logic              en,
    output logic              count_reset,
    output logic              upnotdown,
    output logic [7:0]        prescale,
    output logic [NCH-1:0]    pwm_en,
    output logic [NCH*8-1:0]  functions,
    output logic [NCH*CW-1:0] compare1,
    output logic [NCH*CW-1:0] compare2,
    output logic              irq
);
    logic [CW-1:0] per_sh;
    logic [CW-1:0] c1_sh [NCH];
    logic [CW-1:0] c1_act [NCH];
    logic [CW-1:0] c2_sh [NCH];
    logic [CW-1:0] c2_act [NCH];
    logic [7:0]    fn [NCH];
    logic          auto_load, pending, ovf_f, loaded_f;
    logic [1:0]    irq_en, cr_cnt;
    logic [7:0]    rd;
    logic [2:0]    ch;
    logic          chan, load, sh_wr;
    assign chan = |addr[5:4];
    assign count_reset = |cr_cnt;
    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign functions[8*g +: 8]  = fn[g];
            assign compare1[CW*g +: CW] = c1_act[g];
            assign compare2[CW*g +: CW] = c2_act[g];
        end
    endgenerate
    always_comb begin
        ch    = addr[5:3] - 3'd2;
        load  = (auto_load & counter_ovf) | (write && addr == 6'h08 && data_write[0]);
        sh_wr = write && (addr == 6'h00 || addr == 6'h01);
        case (addr)
            6'h00:   rd = per_sh[7:0];
            6'h01:   rd = 8'(per_sh[CW-1:8]);
            6'h02:   rd = {7'b0, en};
            6'h04:   rd = counter_val[7:0];
            6'h05:   rd = 8'(counter_val[CW-1:8]);
            6'h06:   rd = prescale;
            6'h07:   rd = {7'b0, upnotdown};
            6'h08:   rd = {6'b0, auto_load, 1'b0};
            6'h09:   rd = {5'b0, loaded_f, ovf_f, pending};
            6'h0A:   rd = {5'b0, irq_en, 1'b0};
            default: rd = 8'h00;
        endcase
        // Only instantiated channels decode, so blocks with n >= NCH stay unmapped.
        for (int i = 0; i < NCH; i++) begin
            if (chan && ch == 3'(i)) begin
                sh_wr = sh_wr | (write && (addr[2:1] == 2'd1 || addr[2:1] == 2'd2));
                case (addr[2:0])
                    3'd0:    rd = {7'b0, pwm_en[i]};
                    3'd1:    rd = fn[i];
                    3'd2:    rd = c1_sh[i][7:0];
                    3'd3:    rd = 8'(c1_sh[i][CW-1:8]);
                    3'd4:    rd = c2_sh[i][7:0];
                    3'd5:    rd = 8'(c2_sh[i][CW-1:8]);
                    default: rd = 8'h00;
                endcase
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_read <= 8'h00;
            per_sh    <= '0;
            period    <= '0;
            en        <= 1'b0;
            upnotdown <= 1'b0;
            prescale  <= 8'h00;
            auto_load <= 1'b0;
            pending   <= 1'b0;
            ovf_f     <= 1'b0;
            loaded_f  <= 1'b0;
            irq_en    <= 2'b00;
            cr_cnt    <= 2'd0;
            irq       <= 1'b0;
            pwm_en    <= '0;
            for (int i = 0; i < NCH; i++) begin
                fn[i]     <= 8'h00;
                c1_sh[i]  <= '0;
                c1_act[i] <= '0;
                c2_sh[i]  <= '0;
                c2_act[i] <= '0;
            end
        end else begin
            data_read <= (read && !write) ? rd : 8'h00;
            // Load copies the pre-write shadow; a same-edge shadow write lands after.
            if (load) begin
                period <= per_sh;
                for (int i = 0; i < NCH; i++) begin
                    c1_act[i] <= c1_sh[i];
                    c2_act[i] <= c2_sh[i];
                end
            end
            pending  <= sh_wr | (pending & ~load);
            ovf_f    <= counter_ovf | (ovf_f & ~(write && addr == 6'h09 && data_write[1]));
            loaded_f <= load | (loaded_f & ~(write && addr == 6'h09 && data_write[2]));
            irq      <= (ovf_f & irq_en[0]) | (loaded_f & irq_en[1]);
            cr_cnt   <= (write && addr == 6'h03 && data_write[0]) ? 2'd2 : cr_cnt - {1'b0, |cr_cnt};
            if (write) begin
                case (addr)
                    6'h00:   per_sh[7:0] <= data_write;
                    6'h01:   per_sh[CW-1:8] <= data_write[CW-9:0];
                    6'h02:   en <= data_write[0];
                    6'h06:   prescale <= data_write;
                    6'h07:   upnotdown <= data_write[0];
                    6'h08:   auto_load <= data_write[1];
                    6'h0A:   irq_en <= data_write[2:1];
                    default: ;
                endcase
            end
            for (int i = 0; i < NCH; i++) begin
                if (write && chan && ch == 3'(i)) begin
                    case (addr[2:0])
                        3'd0:    pwm_en[i] <= data_write[0];
                        3'd1:    fn[i] <= data_write;
                        3'd2:    c1_sh[i][7:0] <= data_write;
                        3'd3:    c1_sh[i][CW-1:8] <= data_write[CW-9:0];
                        3'd4:    c2_sh[i][7:0] <= data_write;
                        3'd5:    c2_sh[i][CW-1:8] <= data_write[CW-9:0];
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_regs_multi.sv
// tb_pwm_regs_multi: directed self-checking bench for pwm_regs_multi (NCH=4, CW=16).
module tb_pwm_regs_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [5:0]  addr = 6'h00;
    logic [7:0]  data_write = 8'h00;
    logic [7:0]  data_read;
    logic [15:0] counter_val = 16'h0000;
    logic        counter_ovf = 1'b0;
    logic [15:0] period;
    logic        en, count_reset, upnotdown, irq;
    logic [7:0]  prescale;
    logic [3:0]  pwm_en;
    logic [31:0] functions;
    logic [63:0] compare1, compare2;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] v;

    pwm_regs_multi #(.NCH(4), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
        .counter_ovf(counter_ovf), .period(period), .en(en), .count_reset(count_reset),
        .upnotdown(upnotdown), .prescale(prescale), .pwm_en(pwm_en), .functions(functions),
        .compare1(compare1), .compare2(compare2), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1; addr = a; data_write = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rdb(input logic [5:0] a, output logic [7:0] r);
        @(negedge clk);
        read = 1'b1; addr = a;
        @(negedge clk);
        read = 1'b0;
        r = data_read;
    endtask

    task automatic test_reset;
        logic [5:0] ga [8];
        ga = '{6'h00, 6'h01, 6'h02, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({period, en, count_reset, upnotdown, prescale, pwm_en, functions, irq, data_read} !== '0 ||
            compare1 !== 64'h0 || compare2 !== 64'h0) begin
            n_err++;
            $display("FAIL reset_outputs: period=%h en=%b cr=%b ud=%b ps=%h pe=%h fn=%h c1=%h c2=%h irq=%b dr=%h, required all 0",
                     period, en, count_reset, upnotdown, prescale, pwm_en, functions, compare1, compare2, irq, data_read);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdb(ga[i], v);
            n_cmp++;
            if (v !== 8'h00) begin n_err++; $display("FAIL reset_read addr=%h got %h required 00", ga[i], v); end
        end
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 6; o++) begin
                rdb(6'(16 + 8 * c + o), v);
                n_cmp++;
                if (v !== 8'h00) begin n_err++; $display("FAIL reset_read_ch addr=%h got %h required 00", 6'(16 + 8 * c + o), v); end
            end
        counter_val = 16'h1234;
        rdb(6'h04, v);
        n_cmp++;
        if (v !== 8'h34) begin n_err++; $display("FAIL cnt_l got %h required 34", v); end
        rdb(6'h05, v);
        n_cmp++;
        if (v !== 8'h12) begin n_err++; $display("FAIL cnt_h got %h required 12", v); end
    endtask

    task automatic test_shadow_force;
        wr(6'h08, 8'h00);
        wr(6'h00, 8'hE8);
        wr(6'h01, 8'h03);
        n_cmp++;
        if (period !== 16'h0000) begin n_err++; $display("FAIL period_held got %h required 0000", period); end
        rdb(6'h00, v);
        n_cmp++;
        if (v !== 8'hE8) begin n_err++; $display("FAIL period_l_rb got %h required e8", v); end
        rdb(6'h01, v);
        n_cmp++;
        if (v !== 8'h03) begin n_err++; $display("FAIL period_h_rb got %h required 03", v); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h01) begin n_err++; $display("FAIL status_pending got %h required 01", v); end
        wr(6'h08, 8'h01);
        n_cmp++;
        if (period !== 16'h03E8) begin n_err++; $display("FAIL force_load_period got %h required 03e8", period); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h04) begin n_err++; $display("FAIL status_loaded got %h required 04", v); end
        rdb(6'h08, v);
        n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("FAIL force_selfclear got %h required 00", v); end
    endtask

    task automatic test_auto_load_irq;
        wr(6'h08, 8'h02);
        wr(6'h22, 8'h00);
        wr(6'h23, 8'h01);
        n_cmp++;
        if (compare1[47:32] !== 16'h0000) begin n_err++; $display("FAIL cmp1_held got %h required 0000", compare1[47:32]); end
        @(negedge clk) counter_ovf = 1'b1;
        @(negedge clk) counter_ovf = 1'b0;
        n_cmp++;
        if (compare1 !== 64'h0000_0100_0000_0000) begin n_err++; $display("FAIL auto_load_cmp1 got %h required 0000010000000000", compare1); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h06) begin n_err++; $display("FAIL status_ovf got %h required 06", v); end
        wr(6'h0A, 8'h02);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_ovf got %b required 1", irq); end
        wr(6'h09, 8'h02);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got %b required 0", irq); end
    endtask

    task automatic test_count_reset;
        logic [2:0] seen;
        wr(6'h03, 8'h00);
        n_cmp++;
        if (count_reset !== 1'b0) begin n_err++; $display("FAIL cr_bit0_zero got %b required 0", count_reset); end
        @(negedge clk);
        write = 1'b1; addr = 6'h03; data_write = 8'h01;
        @(negedge clk) write = 1'b0;
        seen[0] = count_reset;
        @(negedge clk) seen[1] = count_reset;
        @(negedge clk) seen[2] = count_reset;
        n_cmp++;
        if (seen !== 3'b011) begin n_err++; $display("FAIL cr_pulse got %b required 011", seen); end
        @(negedge clk);
        write = 1'b1; addr = 6'h03; data_write = 8'h01;
        @(negedge clk);
        @(negedge clk) write = 1'b0;
        seen[0] = count_reset;
        @(negedge clk) seen[1] = count_reset;
        @(negedge clk) seen[2] = count_reset;
        n_cmp++;
        if (seen !== 3'b011) begin n_err++; $display("FAIL cr_retrigger got %b required 011 after two leading highs", seen); end
    endtask

    task automatic test_same_edge;
        wr(6'h14, 8'h55);
        @(negedge clk);
        write = 1'b1; addr = 6'h14; data_write = 8'hAA; counter_ovf = 1'b1;
        @(negedge clk);
        write = 1'b0; counter_ovf = 1'b0;
        n_cmp++;
        if (compare2 !== 64'h0000_0000_0000_0055) begin n_err++; $display("FAIL same_edge_active got %h required 0055", compare2); end
        rdb(6'h14, v);
        n_cmp++;
        if (v !== 8'hAA) begin n_err++; $display("FAIL same_edge_shadow got %h required aa", v); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h07) begin n_err++; $display("FAIL same_edge_pending got %h required 07", v); end
        @(negedge clk);
        write = 1'b1; addr = 6'h09; data_write = 8'h06; counter_ovf = 1'b1;
        @(negedge clk);
        write = 1'b0; counter_ovf = 1'b0;
        n_cmp++;
        if (compare2 !== 64'h0000_0000_0000_00AA) begin n_err++; $display("FAIL set_wins_load got %h required 00aa", compare2); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h06) begin n_err++; $display("FAIL set_wins_flags got %h required 06", v); end
    endtask

    task automatic test_controls;
        wr(6'h18, 8'h01);
        wr(6'h19, 8'h5A);
        wr(6'h02, 8'h01);
        wr(6'h06, 8'h7F);
        wr(6'h07, 8'h01);
        n_cmp++;
        if ({pwm_en, functions, en, prescale, upnotdown} !== {4'b0010, 32'h0000_5A00, 1'b1, 8'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL controls pe=%b fn=%h en=%b ps=%h ud=%b required 0010 00005a00 1 7f 1", pwm_en, functions, en, prescale, upnotdown);
        end
        rdb(6'h19, v);
        n_cmp++;
        if (v !== 8'h5A) begin n_err++; $display("FAIL fn_rb got %h required 5a", v); end
    endtask

    task automatic test_unmapped;
        wr(6'h30, 8'hFF);
        wr(6'h31, 8'hFF);
        wr(6'h32, 8'hFF);
        wr(6'h16, 8'hFF);
        wr(6'h1E, 8'hFF);
        wr(6'h0B, 8'hFF);
        rdb(6'h30, v);
        n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("FAIL unmapped_ch4 got %h required 00", v); end
        rdb(6'h16, v);
        n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("FAIL unmapped_b6 got %h required 00", v); end
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h06) begin n_err++; $display("FAIL unmapped_pending got %h required 06", v); end
        n_cmp++;
        if ({pwm_en, functions, period} !== {4'b0010, 32'h0000_5A00, 16'h03E8} ||
            compare1 !== 64'h0000_0100_0000_0000 || compare2 !== 64'h0000_0000_0000_00AA) begin
            n_err++;
            $display("FAIL unmapped_outputs pe=%b fn=%h per=%h c1=%h c2=%h changed", pwm_en, functions, period, compare1, compare2);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        write = 1'b1; addr = 6'h03; data_write = 8'h01;
        @(negedge clk) write = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({count_reset, period, en, pwm_en, irq} !== '0 || compare1 !== 64'h0 || compare2 !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset cr=%b per=%h en=%b pe=%b irq=%b c1=%h c2=%h required 0", count_reset, period, en, pwm_en, irq, compare1, compare2);
        end
        @(negedge clk) rst_n = 1'b1;
        rdb(6'h09, v);
        n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("FAIL async_reset_status got %h required 00", v); end
    endtask

    initial begin
        test_reset;
        test_shadow_force;
        test_auto_load_irq;
        test_count_reset;
        test_same_edge;
        test_controls;
        test_unmapped;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
